// File: rtl/ct_ctrl.sv
// Packet sequencer for the CT datapath: gathers six operand nibbles, waits EXEC_CYC cycles,
// captures ct_out and holds it until taken. Define CT_CTRL_CNT_EN to add the op_count output.
module ct_ctrl #(
    parameter int unsigned EXEC_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [4:0] in_op,
    output logic [4:0] ct_opcode,
    output logic [3:0] ct_n0,
    output logic [3:0] ct_n1,
    output logic [3:0] ct_n2,
    output logic [3:0] ct_n3,
    output logic [3:0] ct_n4,
    output logic [3:0] ct_n5,
    input  logic [8:0] ct_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_data,
`ifdef CT_CTRL_CNT_EN
    output logic [15:0] op_count,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StHold} state_e;

    localparam logic [3:0] LastCnt = 4'(EXEC_CYC - 1);

    state_e     state_q, state_d;
    logic [2:0] slot_q;
    logic [3:0] cnt_q;
    logic [4:0] opcode_q;
    logic [3:0] slots_q [6];
    logic [8:0] out_data_q;
    logic       out_valid_q;
    logic       accept;
    logic       capture;
    logic       release_res;

    // in_ready is forced low combinationally while reset is asserted
    assign in_ready    = rst_n && (state_q == StIdle || state_q == StLoad);
    assign accept      = in_valid && in_ready;
    assign capture     = (state_q == StExec) && (cnt_q == LastCnt);
    assign release_res = (state_q == StHold) && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StLoad;
            StLoad: if (accept && slot_q == 3'd5) state_d = StExec;
            StExec: if (capture) state_d = StHold;
            StHold: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            slot_q      <= 3'd0;
            cnt_q       <= 4'd0;
            opcode_q    <= 5'd0;
            out_data_q  <= 9'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 6; i++) slots_q[i] <= 4'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (state_q == StIdle) begin
                    slots_q[0] <= in_data;
                    opcode_q   <= in_op;
                    slot_q     <= 3'd1;
                end else begin
                    for (int i = 1; i < 6; i++) begin
                        if (slot_q == 3'(i)) slots_q[i] <= in_data;
                    end
                    slot_q <= (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
                end
            end
            if (state_q == StExec) cnt_q <= capture ? 4'd0 : cnt_q + 4'd1;
            if (capture) begin
                out_data_q  <= ct_out;
                out_valid_q <= 1'b1;
            end
            if (release_res) out_valid_q <= 1'b0;
        end
    end

`ifdef CT_CTRL_CNT_EN
    logic [15:0] op_count_q;

    // Counts completed output handshakes; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= 16'd0;
        end else if (release_res) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

    assign ct_opcode = opcode_q;
    assign ct_n0     = slots_q[0];
    assign ct_n1     = slots_q[1];
    assign ct_n2     = slots_q[2];
    assign ct_n3     = slots_q[3];
    assign ct_n4     = slots_q[4];
    assign ct_n5     = slots_q[5];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/ct_ctrl.md
CT_CTRL -- requirements
Module: ct_ctrl

Interface
REQ-001 Parameter EXEC_CYC, default 1, SHALL set the number of cycles the CT datapath is given to settle before capture (legal 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL flag a valid operand beat on in_data.
REQ-005 in_ready  output  1  SHALL flag that ct_ctrl accepts a beat this cycle.
REQ-006 in_data  input  4  SHALL carry one operand nibble per accepted beat.
REQ-007 in_op  input  5  SHALL carry the opcode, sampled on the first beat of a packet only.
REQ-008 ct_opcode  output  5  SHALL drive the CT opcode port.
REQ-009 ct_n0 .. ct_n5  output  4 each  SHALL drive the CT in_n0..in_n5 ports (six separate ports).
REQ-010 ct_out  input  9  SHALL receive the CT out_n result.
REQ-011 out_valid  output  1  SHALL flag a valid result on out_data.
REQ-012 out_ready  input  1  SHALL flag that the consumer takes the result.
REQ-013 out_data  output  9  SHALL carry the captured CT result.
REQ-014 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, EXEC, HOLD.
REQ-016 Beat acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and LOAD, 0 in EXEC and HOLD.
REQ-017 IDLE: accepted beat -> in_data into ct_n0, in_op into ct_opcode, slot index=1, go LOAD; no beat -> stay.
REQ-018 LOAD: each accepted beat SHALL write slot index (1..5) and increment it; accepting slot 5 SHALL go EXEC; in_valid low SHALL hold state and slots unchanged (gaps allowed, no timeout).
REQ-019 in_op SHALL be ignored on beats 2..6.
REQ-020 ct_opcode and ct_n0..ct_n5 SHALL be registered outputs, changed only by accepted beats, stable through EXEC and HOLD.
REQ-021 EXEC: a 4-bit counter SHALL count EXEC_CYC cycles; on the edge ending the last EXEC cycle, out_data<=ct_out, out_valid<=1, go HOLD.
REQ-022 Latency: beat 6 accepted at edge k -> out_valid high after edge k+EXEC_CYC.
REQ-023 HOLD: out_valid and out_data SHALL stay stable until an edge with out_ready=1; that edge SHALL clear out_valid and go IDLE, in_ready high the following cycle (no overlap, no skid buffer).
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 out_data SHALL retain its last value after out_valid falls.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, slot index 0, EXEC counter 0, ct_opcode=0, ct_n0..ct_n5=0, out_data=0, out_valid=0, busy=0, in_ready=1 while out of reset.
REQ-027 Reset mid-packet or mid-HOLD SHALL discard the partial packet or pending result; no result SHALL be emitted for it.
REQ-028 in_ready SHALL be 0 while rst_n is low.

Configuration
REQ-029 With CT_CTRL_CNT_EN defined, output op_count (16 bits) SHALL exist, reset to 0, increment on each output handshake, wrap 65535->0.
REQ-030 Without CT_CTRL_CNT_EN, the op_count port and counter SHALL be absent; all other behaviour identical.

Verification (bench stub: ct_out = sum of the six nibbles, zero-extended)
REQ-031 Beats 1,2,3,4,5,6 back-to-back, in_op=5'd7 on beat 1, out_ready=1, EXEC_CYC=1 -> ct_opcode=7, out_valid high one cycle after beat-6 edge, out_data=21, then IDLE.
REQ-032 Beats F,F,F,F,F,F with in_valid gaps of 3 cycles between beats, in_op changed to 5'd3 on beat 4 -> ct_opcode stays as beat-1 value, out_data=90.
REQ-033 Result pending, out_ready=0 for 10 cycles, in_valid=1 throughout -> in_ready=0, out_data stable, no beat accepted; out_ready=1 -> out_valid low next cycle, in_ready=1.
REQ-034 rst_n pulsed low after beat 3 -> all outputs 0, next 6 beats 1..6 -> out_data=21 (no stale slots).
REQ-035 EXEC_CYC=15, beats 0,0,0,0,0,1 -> out_valid exactly 15 cycles after beat-6 edge, out_data=1.
REQ-036 CT_CTRL_CNT_EN defined, 65537 completed packets -> op_count=1; undefined build compiles without op_count.
